bram_play_loop: RTL and testbench

BRAM_PLAY_LOOP -- requirements
Module: bram_play_loop

---
 rtl/bram_play_pkg.sv | 24 ++
 rtl/bram_play_loop_if.sv | 12 +
 rtl/bram_play_loop_fifo.sv | 53 +++++
 rtl/bram_play_loop.sv | 153 +++++++++++++++
 tb/tb_bram_play_loop.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_play_pkg.sv
// Shared types and elaboration-time helpers for the BRAM loop player.
package bram_play_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   function automatic int mem_words(input int mem_bytes, input int dwidth);
      return mem_bytes / (dwidth / 8);
   endfunction

   function automatic int calc_awidth(input int mem_bytes, input int dwidth);
      return $clog2(mem_words(mem_bytes, dwidth));
   endfunction

   // Wide enough to hold FIFO_DEPTH itself, which bounds count and inflight.
   function automatic int cred_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/bram_play_loop_if.sv
// AXI-Stream master bundle driven by the player.
interface bram_play_loop_if #(
   parameter int DWIDTH = 128
) ();
   logic [DWIDTH-1:0] axis_tdata;
   logic              axis_tvalid;
   logic              axis_tlast;
   logic              axis_tready;

   modport master (output axis_tdata, output axis_tvalid, output axis_tlast, input axis_tready);
   modport slave  (input axis_tdata, input axis_tvalid, input axis_tlast, output axis_tready);
endinterface

// File: rtl/bram_play_loop_fifo.sv
// Show-ahead synchronous FIFO; head word is visible on rd_data while not empty.
module bram_play_fifo #(
   parameter  int WIDTH = 129,
   parameter  int DEPTH = 8,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_wr, do_rd;

   always_comb begin
      do_wr    = wr_en && (count_q != CW'(DEPTH));
      do_rd    = rd_en && (count_q != '0);
      wr_ptr_d = wr_ptr_q + PW'(do_wr);
      rd_ptr_d = rd_ptr_q + PW'(do_rd);
      count_d  = count_q + CW'(do_wr) - CW'(do_rd);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign empty   = (count_q == '0);
   assign count   = count_q;

endmodule

// File: rtl/bram_play_loop.sv
// Streams a BRAM region out over AXI-Stream, once or in a loop, with
// credit-based read issue so the output buffer can never overflow.
module bram_play_loop
   import bram_play_pkg::*;
#(
   parameter  int DWIDTH         = 128,
   parameter  int MEM_SIZE_BYTES = 131072,
   parameter  int RD_LAT         = 2,
   parameter  int FIFO_DEPTH     = 8,
   localparam int AWIDTH         = calc_awidth(MEM_SIZE_BYTES, DWIDTH)
) (
   input  logic                axis_clk,
   input  logic                axis_aresetn,
   input  logic                enable,
   input  logic                oneshot,
   input  logic [AWIDTH:0]     play_len,
   output logic                portA_clk,
   output logic                portA_rst,
   output logic                portA_en,
   output logic [DWIDTH/8-1:0] portA_we,
   output logic [DWIDTH-1:0]   portA_cpu_wdata,
   output logic [31:0]         portAcpu_addr,
   input  logic [DWIDTH-1:0]   portA_cpu_rdata,
   bram_play_loop_if.master    axis,
   output logic                busy,
   output logic                done
);

   localparam int BYTES  = DWIDTH / 8;
   localparam int WORDS  = mem_words(MEM_SIZE_BYTES, DWIDTH);
   localparam int CW     = cred_width(FIFO_DEPTH);
   localparam int STAGES = RD_LAT - 1;
   localparam logic [AWIDTH:0] ONE = (AWIDTH+1)'(1);

   state_e              state_q, state_d;
   logic [AWIDTH:0]     len_q, len_d;
   logic [AWIDTH:0]     index_q, index_d;
   logic                oneshot_q, oneshot_d;
   logic                pass_done_q, pass_done_d;
   logic [STAGES:0]     vld_pipe_q, vld_pipe_d;
   logic [STAGES:0]     lst_pipe_q, lst_pipe_d;

   logic                issue;
   logic                at_last;
   logic [CW-1:0]       fifo_count;
   logic [CW-1:0]       inflight;
   logic signed [CW+1:0] credits;
   logic                fifo_empty;
   logic                fifo_rd;
   logic [DWIDTH:0]     fifo_head;

   // inflight covers reads issued but not yet written, including the write cycle.
   assign inflight = CW'($countones(vld_pipe_q));
   assign credits  = $signed((CW+2)'(FIFO_DEPTH)) - $signed({2'b00, fifo_count})
                   - $signed({2'b00, inflight});
   assign at_last  = (index_q == len_q - ONE);

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      index_d     = index_q;
      oneshot_d   = oneshot_q;
      pass_done_d = pass_done_q;
      issue       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               len_d       = (play_len == '0) ? (AWIDTH+1)'(WORDS) : play_len;
               oneshot_d   = oneshot;
               index_d     = '0;
               pass_done_d = 1'b0;
               state_d     = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_d = ST_DRAIN;
            end else if (credits > 0) begin
               issue = 1'b1;
               if (at_last) begin
                  index_d = '0;
                  if (oneshot_q) begin
                     pass_done_d = 1'b1;
                     state_d     = ST_DRAIN;
                  end
               end else begin
                  index_d = index_q + ONE;
               end
            end
         end
         ST_DRAIN: begin
            if (inflight == '0 && fifo_empty)
               state_d = pass_done_q ? ST_DONE : ST_IDLE;
         end
         ST_DONE: begin
            if (!enable) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      vld_pipe_d = RD_LAT'({vld_pipe_q, issue});
      lst_pipe_d = RD_LAT'({lst_pipe_q, issue && at_last});
   end

   always_ff @(posedge axis_clk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         index_q     <= '0;
         oneshot_q   <= 1'b0;
         pass_done_q <= 1'b0;
         vld_pipe_q  <= '0;
         lst_pipe_q  <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         index_q     <= index_d;
         oneshot_q   <= oneshot_d;
         pass_done_q <= pass_done_d;
         vld_pipe_q  <= vld_pipe_d;
         lst_pipe_q  <= lst_pipe_d;
      end
   end

   bram_play_fifo #(
      .WIDTH (DWIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (axis_clk),
      .rst_n   (axis_aresetn),
      .wr_en   (vld_pipe_q[STAGES]),
      .wr_data ({lst_pipe_q[STAGES], portA_cpu_rdata}),
      .rd_en   (fifo_rd),
      .rd_data (fifo_head),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign fifo_rd          = axis.axis_tvalid && axis.axis_tready;
   assign axis.axis_tvalid = !fifo_empty;
   assign axis.axis_tdata  = fifo_head[DWIDTH-1:0];
   assign axis.axis_tlast  = !fifo_empty && fifo_head[DWIDTH];

   assign portA_clk       = axis_clk;
   assign portA_rst       = ~axis_aresetn;
   assign portA_we        = '0;
   assign portA_cpu_wdata = '0;
   assign portA_en        = issue;
   assign portAcpu_addr   = 32'(index_q) * 32'(BYTES);

   assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_bram_play_loop.sv
// Randomized self-checking bench: BRAM content model plus a beat-sequence reference.
`timescale 1ns/1ps
module tb_bram_play_loop;

   localparam int DWIDTH = 128;
   localparam int MEM    = 131072;
   localparam int RD_LAT = 2;
   localparam int DEPTH  = 8;
   localparam int AW     = 13;
   localparam int WORDS  = MEM / (DWIDTH / 8);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enable = 1'b0;
   logic oneshot = 1'b0;
   logic [AW:0] play_len = '0;
   logic pa_clk, pa_rst, pa_en;
   logic [DWIDTH/8-1:0] pa_we;
   logic [DWIDTH-1:0] pa_wdata;
   logic [31:0] pa_addr;
   logic [DWIDTH-1:0] pa_rdata;
   logic busy, done;

   bram_play_loop_if #(.DWIDTH(DWIDTH)) axis_if ();

   bram_play_loop #(
      .DWIDTH(DWIDTH), .MEM_SIZE_BYTES(MEM), .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)
   ) dut (
      .axis_clk(clk), .axis_aresetn(rst_n), .enable(enable), .oneshot(oneshot),
      .play_len(play_len), .portA_clk(pa_clk), .portA_rst(pa_rst), .portA_en(pa_en),
      .portA_we(pa_we), .portA_cpu_wdata(pa_wdata), .portAcpu_addr(pa_addr),
      .portA_cpu_rdata(pa_rdata), .axis(axis_if), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit rnd_ready = 1'b0;

   function automatic logic [DWIDTH-1:0] pat(input int unsigned w);
      return {w, w ^ 32'hDEADBEEF, ~w, w * 32'd2654435761};
   endfunction

   // BRAM content model: word w holds pat(w), RD_LAT cycles after the enable.
   logic [DWIDTH-1:0] rd_pipe [RD_LAT];
   always @(posedge clk) begin
      if (pa_en) rd_pipe[0] <= pat(pa_addr >> 4);
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign pa_rdata = rd_pipe[RD_LAT-1];

   typedef struct {
      logic [DWIDTH-1:0] data;
      logic              last;
   } beat_t;

   beat_t beats[$];
   logic [31:0] addrs[$];
   int en_cnt = 0, beat_cnt = 0, ovf_cnt = 0, stall_viol = 0, lost = 0;
   logic prev_stall = 1'b0;
   logic [DWIDTH-1:0] prev_data;
   logic prev_last;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
         lost = en_cnt - beat_cnt;
      end else begin
         if (prev_stall && (!axis_if.axis_tvalid || axis_if.axis_tdata !== prev_data ||
                            axis_if.axis_tlast !== prev_last))
            stall_viol++;
         if (pa_en) begin
            addrs.push_back(pa_addr);
            en_cnt++;
         end
         if (axis_if.axis_tvalid && axis_if.axis_tready) begin
            beats.push_back('{axis_if.axis_tdata, axis_if.axis_tlast});
            beat_cnt++;
         end
         if (en_cnt - beat_cnt - lost > DEPTH) ovf_cnt++;
         prev_stall = axis_if.axis_tvalid && !axis_if.axis_tready;
         prev_data  = axis_if.axis_tdata;
         prev_last  = axis_if.axis_tlast;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd_ready) axis_if.axis_tready = ($urandom_range(0, 99) < 50);
   endtask

   task automatic wait_beats(input int n, input int max, output bit ok);
      int c = 0;
      while (beats.size() < n && c < max) begin step(); c++; end
      ok = (beats.size() >= n);
   endtask

   task automatic wait_idle(input int max, output bit ok);
      int c = 0;
      while (busy && c < max) begin step(); c++; end
      ok = !busy;
   endtask

   task automatic wait_done(input int max, output bit ok);
      int c = 0;
      while (!done && c < max) begin step(); c++; end
      ok = done;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; axis_if.axis_tready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (axis_if.axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b want 0", axis_if.axis_tvalid); end
      n_vec++; if (axis_if.axis_tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast got %b want 0", axis_if.axis_tlast); end
      n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_status got busy=%b done=%b want 0/0", busy, done); end
      n_vec++; if (pa_en !== 1'b0 || pa_addr !== 32'd0) begin n_err++; $display("FAIL reset_bram got en=%b addr=%0d want 0/0", pa_en, pa_addr); end
      n_vec++; if (pa_we !== '0 || pa_wdata !== '0 || pa_rst !== 1'b1) begin n_err++; $display("FAIL reset_ties got we=%h rst=%b want 0/1", pa_we, pa_rst); end
      rst_n = 1'b1;
      step();
      n_vec++; if (pa_rst !== 1'b0) begin n_err++; $display("FAIL reset_release got portA_rst=%b want 0", pa_rst); end
   endtask

   task automatic test_oneshot4();
      int bb = beats.size(), ab = addrs.size(), eb = en_cnt, lat, bad = -1;
      bit ok;
      axis_if.axis_tready = 1'b1;
      play_len = (AW+1)'(4); oneshot = 1'b1; enable = 1'b1;
      for (lat = 0; lat < 50; lat++) begin
         @(negedge clk);
         if (axis_if.axis_tvalid) break;
      end
      n_vec++; if (lat != RD_LAT + 2) begin n_err++; $display("FAIL first_beat_latency got %0d want %0d", lat, RD_LAT + 2); end
      wait_done(100, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL oneshot_done got done=%b want 1", done); end
      n_vec++; if (beats.size() - bb != 4) begin n_err++; $display("FAIL oneshot_beats got %0d want 4", beats.size() - bb); end
      for (int i = 0; i < 4 && bb + i < beats.size(); i++)
         if (bad < 0 && (beats[bb+i].data !== pat(i) || beats[bb+i].last !== (i == 3))) bad = i;
      n_vec++; if (bad >= 0) begin n_err++; $display("FAIL oneshot_data first bad beat %0d got last=%b want word %0d", bad, beats[bb+bad].last, bad); end
      bad = -1;
      for (int i = 0; i < 4 && ab + i < addrs.size(); i++)
         if (bad < 0 && addrs[ab+i] !== 32'(i * 16)) bad = i;
      n_vec++; if (bad >= 0) begin n_err++; $display("FAIL oneshot_addr read %0d got %0d want %0d", bad, addrs[ab+bad], bad * 16); end
      repeat (10) step();
      n_vec++; if (en_cnt - eb != 4 || done !== 1'b1) begin n_err++; $display("FAIL oneshot_hold got reads=%0d done=%b want 4/1", en_cnt - eb, done); end
      enable = 1'b0;
      step(); step();
      n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL oneshot_release got done=%b busy=%b want 0/0", done, busy); end
   endtask

   task automatic test_loop3();
      int bb = beats.size(), eb = en_cnt, bad = -1;
      bit ok;
      axis_if.axis_tready = 1'b1;
      play_len = (AW+1)'(3); oneshot = 1'b0; enable = 1'b1;
      wait_beats(bb + 10, 100, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL loop_beats got %0d want >=10", beats.size() - bb); end
      for (int i = 0; i < 10 && bb + i < beats.size(); i++)
         if (bad < 0 && (beats[bb+i].data !== pat(i % 3) || beats[bb+i].last !== (i % 3 == 2))) bad = i;
      n_vec++; if (bad >= 0) begin n_err++; $display("FAIL loop_seq beat %0d got last=%b want word %0d last=%b", bad, beats[bb+bad].last, bad % 3, bad % 3 == 2); end
      enable = 1'b0;
      wait_idle(100, ok);
      n_vec++; if (!ok || done !== 1'b0) begin n_err++; $display("FAIL loop_stop got busy=%b done=%b want 0/0", busy, done); end
      n_vec++; if (beats.size() - bb != en_cnt - eb) begin n_err++; $display("FAIL loop_loss got beats=%0d want reads=%0d", beats.size() - bb, en_cnt - eb); end
   endtask

   task automatic test_stall();
      int bb = beats.size(), eb = en_cnt, sb = stall_viol, bad = -1;
      bit ok;
      axis_if.axis_tready = 1'b0;
      play_len = '0; oneshot = 1'b0; enable = 1'b1;
      repeat (20) step();
      n_vec++; if (en_cnt - eb != DEPTH) begin n_err++; $display("FAIL stall_reads got %0d want %0d", en_cnt - eb, DEPTH); end
      n_vec++; if (axis_if.axis_tvalid !== 1'b1 || axis_if.axis_tdata !== pat(0)) begin n_err++; $display("FAIL stall_head got valid=%b data=%h want 1/%h", axis_if.axis_tvalid, axis_if.axis_tdata, pat(0)); end
      n_vec++; if (stall_viol != sb) begin n_err++; $display("FAIL stall_stable got %0d changes want 0", stall_viol - sb); end
      enable = 1'b0;
      axis_if.axis_tready = 1'b1;
      wait_idle(100, ok);
      n_vec++; if (!ok || beats.size() - bb != DEPTH) begin n_err++; $display("FAIL stall_drain got beats=%0d want %0d", beats.size() - bb, DEPTH); end
      for (int i = 0; i < DEPTH && bb + i < beats.size(); i++)
         if (bad < 0 && beats[bb+i].data !== pat(i)) bad = i;
      n_vec++; if (bad >= 0) begin n_err++; $display("FAIL stall_order beat %0d got %h want %h", bad, beats[bb+bad].data, pat(bad)); end
   endtask

   task automatic test_stop_mid();
      int bb = beats.size(), eb = en_cnt, bad = -1;
      bit ok;
      axis_if.axis_tready = 1'b1;
      play_len = '0; oneshot = 1'b0; enable = 1'b1;
      repeat (6) step();
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL stop_busy got %b want 1", busy); end
      enable = 1'b0;
      wait_idle(100, ok);
      n_vec++; if (en_cnt - eb != 5) begin n_err++; $display("FAIL stop_reads got %0d want 5", en_cnt - eb); end
      n_vec++; if (!ok || done !== 1'b0) begin n_err++; $display("FAIL stop_state got busy=%b done=%b want 0/0", busy, done); end
      for (int i = 0; i < en_cnt - eb; i++)
         if (bad < 0 && (bb + i >= beats.size() || beats[bb+i].data !== pat(i))) bad = i;
      n_vec++; if (bad >= 0 || beats.size() - bb != en_cnt - eb) begin n_err++; $display("FAIL stop_delivery got beats=%0d first bad %0d want %0d in order", beats.size() - bb, bad, en_cnt - eb); end
   endtask

   task automatic test_random_len();
      int len, bb, bad;
      bit ok;
      for (int t = 0; t < 3; t++) begin
         len = $urandom_range(1, 40);
         bb = beats.size();
         bad = -1;
         rnd_ready = 1'b1;
         play_len = (AW+1)'(len); oneshot = 1'b1; enable = 1'b1;
         wait_done(2000, ok);
         n_vec++; if (!ok || beats.size() - bb != len) begin n_err++; $display("FAIL rlen_count got done=%b beats=%0d want 1/%0d", done, beats.size() - bb, len); end
         for (int i = 0; i < len && bb + i < beats.size(); i++)
            if (bad < 0 && (beats[bb+i].data !== pat(i) || beats[bb+i].last !== (i == len - 1))) bad = i;
         n_vec++; if (bad >= 0) begin n_err++; $display("FAIL rlen_seq len %0d beat %0d got last=%b want word %0d", len, bad, beats[bb+bad].last, bad); end
         enable = 1'b0; rnd_ready = 1'b0; axis_if.axis_tready = 1'b1;
         step(); step();
         n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rlen_idle got done=%b busy=%b want 0/0", done, busy); end
      end
   endtask

   task automatic test_random_full();
      int bb = beats.size(), ab = addrs.size(), eb = en_cnt, ob = ovf_cnt, sb = stall_viol, bad = -1;
      bit ok;
      rnd_ready = 1'b1;
      play_len = '0; oneshot = 1'b0; enable = 1'b1;
      wait_beats(bb + 1000, 10000, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL full_progress got %0d beats want 1000", beats.size() - bb); end
      enable = 1'b0;
      wait_idle(500, ok);
      rnd_ready = 1'b0; axis_if.axis_tready = 1'b1;
      n_vec++; if (!ok || done !== 1'b0) begin n_err++; $display("FAIL full_stop got busy=%b done=%b want 0/0", busy, done); end
      n_vec++; if (beats.size() - bb != en_cnt - eb) begin n_err++; $display("FAIL full_loss got beats=%0d want reads=%0d", beats.size() - bb, en_cnt - eb); end
      for (int i = 0; bb + i < beats.size(); i++)
         if (bad < 0 && (beats[bb+i].data !== pat(i % WORDS) || beats[bb+i].last !== (i % WORDS == WORDS - 1))) bad = i;
      n_vec++; if (bad >= 0) begin n_err++; $display("FAIL full_order beat %0d got %h want %h", bad, beats[bb+bad].data, pat(bad % WORDS)); end
      bad = -1;
      for (int i = 0; ab + i < addrs.size(); i++)
         if (bad < 0 && addrs[ab+i] !== 32'((i % WORDS) * 16)) bad = i;
      n_vec++; if (bad >= 0) begin n_err++; $display("FAIL full_addr read %0d got %0d want %0d", bad, addrs[ab+bad], (bad % WORDS) * 16); end
      n_vec++; if (ovf_cnt != ob) begin n_err++; $display("FAIL full_credit got %0d overcommits want 0", ovf_cnt - ob); end
      n_vec++; if (stall_viol != sb) begin n_err++; $display("FAIL full_stable got %0d changes want 0", stall_viol - sb); end
   endtask

   task automatic test_reset_mid();
      int bb, ab, bad = -1;
      bit ok;
      axis_if.axis_tready = 1'b1;
      play_len = '0; oneshot = 1'b0; enable = 1'b1;
      repeat (6) step();
      @(negedge clk);
      n_vec++; if (axis_if.axis_tvalid !== 1'b1 || pa_en !== 1'b1) begin n_err++; $display("FAIL rmid_pre got valid=%b en=%b want 1/1", axis_if.axis_tvalid, pa_en); end
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (axis_if.axis_tvalid !== 1'b0 || pa_en !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_async got valid=%b en=%b busy=%b want 0/0/0", axis_if.axis_tvalid, pa_en, busy); end
      enable = 1'b0;
      step(); step();
      rst_n = 1'b1;
      step();
      bb = beats.size(); ab = addrs.size();
      play_len = (AW+1)'(4); oneshot = 1'b1; enable = 1'b1;
      wait_done(100, ok);
      n_vec++; if (!ok || addrs.size() - ab != 4 || addrs[ab] !== 32'd0) begin n_err++; $display("FAIL rmid_restart got done=%b reads=%0d want 1/4 from addr 0", done, addrs.size() - ab); end
      for (int i = 0; i < 4 && bb + i < beats.size(); i++)
         if (bad < 0 && beats[bb+i].data !== pat(i)) bad = i;
      n_vec++; if (bad >= 0 || beats.size() - bb != 4) begin n_err++; $display("FAIL rmid_data got beats=%0d first bad %0d want 4 clean", beats.size() - bb, bad); end
      enable = 1'b0;
      step(); step();
   endtask

   initial begin
      #(2_000_000);
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      axis_if.axis_tready = 1'b0;
      test_reset();
      test_oneshot4();
      test_loop3();
      test_stall();
      test_stop_mid();
      test_random_len();
      test_random_full();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
